ksa_schedule_ctrl: RTL

KSA_SCHEDULE_CTRL -- requirements
Module: ksa_schedule_ctrl

---
 rtl/ksa_schedule_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ksa_schedule_ctrl.sv
// RC4 key-scheduling controller: walks i=0..255 over a 256x8 S-RAM with a
// registered-address read port, accumulating j and swapping S[i]/S[j] per step.
module ksa_schedule_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  s_q,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned KIW = 2;

  typedef enum logic [3:0] {
    IDLE, RD_I, WAIT_I, LATCH_I, RD_J, WAIT_J, LATCH_J, WR_I, WR_J, NEXT, DONE
  } state_t;

  state_t         state, state_d;
  logic [AW-1:0]  i, i_d, j, j_d;
  logic [DW-1:0]  si, si_d, sj, sj_d;
  logic [KIW-1:0] kidx, kidx_d;
  logic [DW-1:0]  kbyte;
  logic [AW-1:0]  address_d;
  logic [DW-1:0]  data_d;
  logic           wren_d, busy_d, done_d;

  // Key byte selected by the mod-3 key index
  always_comb begin
    kbyte = secret_key[7:0];
    case (kidx)
      2'd0:    kbyte = secret_key[23:16];
      2'd1:    kbyte = secret_key[15:8];
      default: kbyte = secret_key[7:0];
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state;
    i_d     = i;
    j_d     = j;
    si_d    = si;
    sj_d    = sj;
    kidx_d  = kidx;
    case (state)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = RD_I;
        end
      end
      RD_I:    state_d = WAIT_I;
      WAIT_I: begin
        si_d    = s_q;
        state_d = LATCH_I;
      end
      LATCH_I: begin
        j_d     = AW'(j + si + kbyte);
        state_d = RD_J;
      end
      RD_J:    state_d = WAIT_J;
      WAIT_J: begin
        sj_d    = s_q;
        state_d = LATCH_J;
      end
      LATCH_J: state_d = WR_I;
      WR_I:    state_d = WR_J;
      WR_J:    state_d = NEXT;
      NEXT: begin
        kidx_d = (kidx == KIW'(2)) ? '0 : KIW'(kidx + KIW'(1));
        if (i == AW'(255)) begin
          state_d = DONE;
        end else begin
          i_d     = AW'(i + AW'(1));
          state_d = RD_I;
        end
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state, so every output is a flop
  always_comb begin
    address_d = '0;
    data_d    = '0;
    wren_d    = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_d)
      IDLE:                      busy_d = 1'b0;
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      RD_I, WAIT_I, LATCH_I, NEXT: address_d = i_d;
      RD_J, WAIT_J, LATCH_J:       address_d = j_d;
      WR_I: begin
        address_d = i_d;
        data_d    = sj_d;
        wren_d    = 1'b1;
      end
      WR_J: begin
        address_d = j_d;
        data_d    = si_d;
        wren_d    = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      kidx      <= '0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      i         <= i_d;
      j         <= j_d;
      si        <= si_d;
      sj        <= sj_d;
      kidx      <= kidx_d;
      s_address <= address_d;
      s_data    <= data_d;
      s_wren    <= wren_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
